matched_filter_mac: RTL
=======================

MATCHED_FILTER_MAC -- requirements
Module: matched_filter_mac

Interface
REQ-001 SHALL provide: clk  in  1  single main clock; all state on rising edge.
REQ-002 SHALL provide: reset  in  1  asynchronous, active-low reset.
REQ-003 SHALL provide: tap0..tap9  in  5 each  signed two's-complement window samples from the upstream 10-tap decimating shift register; tap0 = newest.
REQ-004 SHALL provide: taps_valid  in  1  one-cycle pulse; tap0..tap9 hold a new window this cycle.
REQ-005 SHALL provide: clr  in  1  synchronous soft clear.
REQ-006 SHALL provide: filt_out  out  12  signed matched-filter result.
REQ-007 SHALL provide: filt_valid  out  1  one-cycle pulse; filt_out holds a new result.
REQ-008 SHALL provide: busy  out  1  high while a window is being accumulated.
REQ-009 SHALL provide: overrun  out  1  sticky; a taps_valid was dropped.

Function
REQ-010 SHALL compute filt_out = sum over k=0..9 of tap_k * C[k], with C = {1,3,5,6,7,7,6,5,3,1} (half-sine, signed 4-bit).
REQ-011 SHALL compute with full precision: 5x4 signed product is 9 bits, accumulator is 12-bit signed; |result| <= 704, so no saturation logic.
REQ-012 SHALL use FSM states IDLE and MAC; pair index p counts 0..4.
REQ-013 SHALL, in IDLE with taps_valid=1, snapshot all 10 taps, clear the accumulator, set p=0 and go to MAC.
REQ-014 SHALL, on each MAC cycle, add tap_(2p)*C[2p] + tap_(2p+1)*C[2p+1] (snapshot values) to the accumulator and increment p.
REQ-015 SHALL, on the MAC cycle with p=4, register the final sum into filt_out, assert filt_valid for exactly one cycle, and return to IDLE.
REQ-016 SHALL use this latency: filt_valid is high in the cycle beginning 5 rising edges after the edge that sampled taps_valid.
REQ-017 SHALL accept taps_valid during the p=4 MAC cycle: complete the current result and snapshot the new window, staying in MAC with p=0. This gives back-to-back service at the upstream period of 5 cycles.
REQ-018 SHALL treat taps_valid in MAC with p<4 as follows: ignore it, leave the snapshot unchanged and set overrun=1.
REQ-019 SHALL never alter the snapshot or accumulator because of live tap changes during MAC.
REQ-020 SHALL hold filt_out between results; filt_valid SHALL be 0 except as stated in REQ-015.
REQ-021 SHALL drive busy=1 exactly when state=MAC.
REQ-022 SHALL, on clr=1: go to IDLE, set the accumulator, filt_out and p to 0, force filt_valid=0 and clear overrun. clr has priority over taps_valid in the same cycle, and over any completion in progress.

Reset
REQ-023 SHALL, on reset=0 (asynchronous assert): state=IDLE, p=0, accumulator=0, snapshot=0, filt_out=0, filt_valid=0, busy=0, overrun=0.
REQ-024 SHALL, on reset asserted mid-MAC, discard the window; no filt_valid follows reset release.
REQ-025 SHALL leave IDLE after reset release only via taps_valid.

Structure
REQ-026 SHALL place the following in the shared iq_demod_pkg: the coefficient array C, sample width (5), coefficient width (4), accumulator width (12), tap count (10) and the FSM state enum.
REQ-027 SHALL implement the two-product adder as one sub-module, mac_pair (combinational: two signed multiplies plus sum).

Verification
REQ-028 SHALL cover: all taps=+1, one taps_valid -> filt_out=44, filt_valid 5 edges later, single pulse.
REQ-029 SHALL cover: all taps=-16 -> filt_out=-704 (0xD40 in 12 bits).
REQ-030 SHALL cover: tap4=+15, others 0 -> filt_out=105; then tap0=+15, others 0 -> filt_out=15.
REQ-031 SHALL cover: taps_valid every 5 cycles, 3 windows (+1, +2, -1 all taps) -> results 44, 88, -44; overrun=0.
REQ-032 SHALL cover: taps_valid at edges N and N+2 -> one result only; overrun=1 until clr.
REQ-033 SHALL cover:
  - reset pulse at p=2 -> all outputs 0 and no filt_valid afterward;
  - clr together with taps_valid -> state IDLE, no result.

Source files
------------

// File: rtl/iq_demod_pkg.sv
// Shared types and constants for the IQ demodulator datapath: sample/coefficient
// widths, the half-sine matched-filter coefficients and the filter FSM states.
package iq_demod_pkg;

    localparam int SAMPLE_W   = 5;
    localparam int COEF_W     = 4;
    localparam int ACC_W      = 12;
    localparam int NUM_TAPS   = 10;
    localparam int NUM_PAIRS  = NUM_TAPS / 2;
    localparam int PROD_W     = SAMPLE_W + COEF_W;
    localparam int PAIR_W     = PROD_W + 1;
    localparam int PAIR_IDX_W = 3;

    typedef logic signed [SAMPLE_W-1:0] sample_t;
    typedef logic signed [COEF_W-1:0]   coef_t;
    typedef logic signed [PAIR_W-1:0]   pair_sum_t;
    typedef logic signed [ACC_W-1:0]    acc_t;

    // Half-sine pulse shape, index 0 pairs with the newest tap.
    localparam coef_t COEF [NUM_TAPS] = '{
        4'sd1, 4'sd3, 4'sd5, 4'sd6, 4'sd7, 4'sd7, 4'sd6, 4'sd5, 4'sd3, 4'sd1
    };

    typedef enum logic {
        IDLE,
        MAC
    } state_e;

endpackage

// File: rtl/mac_pair.sv
// Combinational two-term multiply-add: sampleA*coefA + sampleB*coefB at full precision.
module mac_pair
    import iq_demod_pkg::*;
(
    input  sample_t   sampleA_i,
    input  sample_t   sampleB_i,
    input  coef_t     coefA_i,
    input  coef_t     coefB_i,
    output pair_sum_t sum_o
);

    logic signed [PROD_W-1:0] prodA;
    logic signed [PROD_W-1:0] prodB;

    // Operands are sign-extended to the product width so the truncated result is exact.
    assign prodA = PROD_W'(sampleA_i) * PROD_W'(coefA_i);
    assign prodB = PROD_W'(sampleB_i) * PROD_W'(coefB_i);
    assign sum_o = PAIR_W'(prodA) + PAIR_W'(prodB);

endmodule

// File: rtl/matched_filter_mac.sv
// Ten-tap half-sine matched filter: snapshots a window, then accumulates one
// tap pair per cycle over five cycles and emits a single-cycle result pulse.
module matched_filter_mac
    import iq_demod_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset,
    input  logic signed [SAMPLE_W-1:0] tap0,
    input  logic signed [SAMPLE_W-1:0] tap1,
    input  logic signed [SAMPLE_W-1:0] tap2,
    input  logic signed [SAMPLE_W-1:0] tap3,
    input  logic signed [SAMPLE_W-1:0] tap4,
    input  logic signed [SAMPLE_W-1:0] tap5,
    input  logic signed [SAMPLE_W-1:0] tap6,
    input  logic signed [SAMPLE_W-1:0] tap7,
    input  logic signed [SAMPLE_W-1:0] tap8,
    input  logic signed [SAMPLE_W-1:0] tap9,
    input  logic                       taps_valid,
    input  logic                       clr,
    output logic signed [ACC_W-1:0]    filt_out,
    output logic                       filt_valid,
    output logic                       busy,
    output logic                       overrun
);

    state_e                state_q, state_d;
    logic [PAIR_IDX_W-1:0] p_q, p_d;
    acc_t                  acc_q, acc_d;
    acc_t                  filtOut_q, filtOut_d;
    logic                  filtValid_q, filtValid_d;
    logic                  overrun_q, overrun_d;
    sample_t               snap_q [NUM_TAPS];
    sample_t               snap_d [NUM_TAPS];
    sample_t               liveTaps [NUM_TAPS];

    sample_t               pairSampleA, pairSampleB;
    coef_t                 pairCoefA, pairCoefB;
    pair_sum_t             pairSum;

    assign liveTaps[0] = tap0;
    assign liveTaps[1] = tap1;
    assign liveTaps[2] = tap2;
    assign liveTaps[3] = tap3;
    assign liveTaps[4] = tap4;
    assign liveTaps[5] = tap5;
    assign liveTaps[6] = tap6;
    assign liveTaps[7] = tap7;
    assign liveTaps[8] = tap8;
    assign liveTaps[9] = tap9;

    // Pair index p steers snapshot taps 2p and 2p+1 into the shared multiply-add.
    always_comb begin
        pairSampleA = snap_q[0];
        pairSampleB = snap_q[1];
        pairCoefA   = COEF[0];
        pairCoefB   = COEF[1];
        for (int k = 0; k < NUM_PAIRS; k++) begin
            if (p_q == PAIR_IDX_W'(k)) begin
                pairSampleA = snap_q[2*k];
                pairSampleB = snap_q[2*k+1];
                pairCoefA   = COEF[2*k];
                pairCoefB   = COEF[2*k+1];
            end
        end
    end

    mac_pair u_mac_pair (
        .sampleA_i (pairSampleA),
        .sampleB_i (pairSampleB),
        .coefA_i   (pairCoefA),
        .coefB_i   (pairCoefB),
        .sum_o     (pairSum)
    );

    always_comb begin
        state_d     = state_q;
        p_d         = p_q;
        acc_d       = acc_q;
        snap_d      = snap_q;
        filtOut_d   = filtOut_q;
        filtValid_d = 1'b0;
        overrun_d   = overrun_q;

        if (clr) begin
            state_d   = IDLE;
            p_d       = '0;
            acc_d     = '0;
            filtOut_d = '0;
            overrun_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (taps_valid) begin
                        snap_d  = liveTaps;
                        acc_d   = '0;
                        p_d     = '0;
                        state_d = MAC;
                    end
                end
                MAC: begin
                    if (p_q == PAIR_IDX_W'(NUM_PAIRS - 1)) begin
                        filtOut_d   = acc_q + ACC_W'(pairSum);
                        filtValid_d = 1'b1;
                        p_d         = '0;
                        acc_d       = '0;
                        // A window arriving on the last pair cycle is taken back-to-back.
                        if (taps_valid) begin
                            snap_d = liveTaps;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        acc_d = acc_q + ACC_W'(pairSum);
                        p_d   = p_q + PAIR_IDX_W'(1);
                        if (taps_valid) begin
                            overrun_d = 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            p_q         <= '0;
            acc_q       <= '0;
            filtOut_q   <= '0;
            filtValid_q <= 1'b0;
            overrun_q   <= 1'b0;
            snap_q      <= '{default: '0};
        end else begin
            state_q     <= state_d;
            p_q         <= p_d;
            acc_q       <= acc_d;
            filtOut_q   <= filtOut_d;
            filtValid_q <= filtValid_d;
            overrun_q   <= overrun_d;
            snap_q      <= snap_d;
        end
    end

    assign filt_out   = filtOut_q;
    assign filt_valid = filtValid_q;
    assign busy       = (state_q == MAC);
    assign overrun    = overrun_q;

endmodule
